// File: rtl/heartbeat_lock_mon.sv
// PLL lock monitor: synchronizes 'locked', qualifies it for a stable interval,
// then releases the downstream reset and drives a lub-dub heartbeat LED.
module heartbeat_lock_mon #(
  parameter int unsigned TICK_DIV          = 100000,
  parameter int unsigned LOCK_STABLE_TICKS = 16,
  parameter int unsigned BEAT_PERIOD_TICKS = 1000,
  parameter int unsigned PULSE_TICKS       = 100,
  parameter int unsigned GAP_TICKS         = 150
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       sys_rst,
  output logic       lock_ok,
  output logic       heartbeat,
  output logic       tick,
  output logic [7:0] lost_cnt
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned QUAL_W  = (LOCK_STABLE_TICKS > 1) ? $clog2(LOCK_STABLE_TICKS) : 1;
  localparam int unsigned BEAT_W  = (BEAT_PERIOD_TICKS > 1) ? $clog2(BEAT_PERIOD_TICKS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [QUAL_W-1:0]  QUAL_MAX  = QUAL_W'(LOCK_STABLE_TICKS - 1);
  localparam logic [BEAT_W-1:0]  BEAT_MAX  = BEAT_W'(BEAT_PERIOD_TICKS - 1);
  localparam logic [BEAT_W-1:0]  P1_END    = BEAT_W'(PULSE_TICKS);
  localparam logic [BEAT_W-1:0]  P2_START  = BEAT_W'(PULSE_TICKS + GAP_TICKS);
  localparam logic [BEAT_W-1:0]  P2_END    = BEAT_W'(2 * PULSE_TICKS + GAP_TICKS);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    QUALIFY   = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic                 locked_m, locked_s;
  logic [PRESC_W-1:0]   presc, presc_nxt;
  logic [QUAL_W-1:0]    qual_cnt, qual_nxt;
  logic [BEAT_W-1:0]    beat_cnt, beat_nxt;
  logic [7:0]           lost_nxt;
  logic                 tick_now;
  logic                 tick_nxt, sys_rst_nxt, lock_ok_nxt, heartbeat_nxt;

  // Next-state, counters and registered-output values
  always_comb begin
    state_nxt     = state;
    qual_nxt      = qual_cnt;
    beat_nxt      = beat_cnt;
    lost_nxt      = lost_cnt;
    tick_now      = (presc == PRESC_MAX);
    presc_nxt     = tick_now ? '0 : presc + PRESC_W'(1);

    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = QUALIFY;
          qual_nxt  = '0;
          presc_nxt = '0;
        end
      end
      QUALIFY: begin
        // Loss of lock outranks a coincident tick and restarts qualification.
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
        end else if (tick_now) begin
          if (qual_cnt == QUAL_MAX) begin
            state_nxt = RUN;
            beat_nxt  = '0;
          end else begin
            qual_nxt = qual_cnt + QUAL_W'(1);
          end
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt = LOST;
          if (lost_cnt != 8'hFF) lost_nxt = lost_cnt + 8'd1;
        end else if (tick_now) begin
          beat_nxt = (beat_cnt == BEAT_MAX) ? '0 : beat_cnt + BEAT_W'(1);
        end
      end
      LOST:    state_nxt = WAIT_LOCK;
      default: state_nxt = WAIT_LOCK;
    endcase

    tick_nxt      = (presc_nxt == PRESC_MAX);
    sys_rst_nxt   = (state_nxt != RUN);
    lock_ok_nxt   = (state_nxt == RUN);
    heartbeat_nxt = (state_nxt == RUN) &&
                    ((beat_nxt < P1_END) || ((beat_nxt >= P2_START) && (beat_nxt < P2_END)));
  end

  // State, synchronizer, counters and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_LOCK;
      locked_m  <= 1'b0;
      locked_s  <= 1'b0;
      presc     <= '0;
      qual_cnt  <= '0;
      beat_cnt  <= '0;
      lost_cnt  <= 8'd0;
      tick      <= 1'b0;
      sys_rst   <= 1'b1;
      lock_ok   <= 1'b0;
      heartbeat <= 1'b0;
    end else begin
      state     <= state_nxt;
      locked_m  <= locked;
      locked_s  <= locked_m;
      presc     <= presc_nxt;
      qual_cnt  <= qual_nxt;
      beat_cnt  <= beat_nxt;
      lost_cnt  <= lost_nxt;
      tick      <= tick_nxt;
      sys_rst   <= sys_rst_nxt;
      lock_ok   <= lock_ok_nxt;
      heartbeat <= heartbeat_nxt;
    end
  end

endmodule

// File: tb/tb_heartbeat_lock_mon.sv
// Directed bench for heartbeat_lock_mon with small tick/beat parameters.
module tb_heartbeat_lock_mon;

  logic       clk;
  logic       rst;
  logic       locked;
  logic       sys_rst;
  logic       lock_ok;
  logic       heartbeat;
  logic       tick;
  logic [7:0] lost_cnt;

  int errors = 0;
  int checks = 0;
  int lat;
  int rlat;

  heartbeat_lock_mon #(
    .TICK_DIV          (4),
    .LOCK_STABLE_TICKS (3),
    .BEAT_PERIOD_TICKS (20),
    .PULSE_TICKS       (2),
    .GAP_TICKS         (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .locked    (locked),
    .sys_rst   (sys_rst),
    .lock_ok   (lock_ok),
    .heartbeat (heartbeat),
    .tick      (tick),
    .lost_cnt  (lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Edges until sys_rst drops; the first edge waited on is index 0 (-1 on timeout)
  task automatic wait_run(output int n);
    n = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (!sys_rst) begin
        n = i;
        break;
      end
    end
  endtask

  // Drop locked from RUN; report edges to sys_rst (first edge = 1) and relock latency
  task automatic lose_and_relock(output int rst_lat, output int run_lat);
    @(negedge clk);
    locked = 1'b0;
    rst_lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (sys_rst) begin
        rst_lat = i;
        break;
      end
    end
    repeat (2) @(negedge clk);
    locked = 1'b1;
    wait_run(run_lat);
  endtask

  initial begin
    rst    = 1'b1;
    locked = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sys_rst", 32'(sys_rst), 32'd1);
    check("rst_lock_ok", 32'(lock_ok), 32'd0);
    check("rst_heartbeat", 32'(heartbeat), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_lost_cnt", 32'(lost_cnt), 32'd0);

    // Clean lock: RUN on the 15th edge
    rst    = 1'b0;
    locked = 1'b1;
    wait_run(lat);
    check("lock_latency", 32'(lat), 32'd14);
    check("run_lock_ok", 32'(lock_ok), 32'd1);
    check("run_heartbeat", 32'(heartbeat), 32'd1);

    // Two heartbeat periods: high 8, low 12, high 8, low 52; tick every 4th cycle
    for (int k = 0; k < 160; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      check("hb_pattern", 32'(heartbeat), 32'(((k % 80) < 8) || (((k % 80) >= 20) && ((k % 80) < 28))));
      check("tick_pattern", 32'(tick), 32'((k % 4) == 3));
    end
    check("run_sys_rst", 32'(sys_rst), 32'd0);

    // Loss in RUN during a pulse: sys_rst on 3rd edge, counted once
    lose_and_relock(rlat, lat);
    check("loss_rst_latency", 32'(rlat), 32'd3);
    check("lost_cnt_one", 32'(lost_cnt), 32'd1);
    check("relock_latency", 32'(lat), 32'd14);
    check("relock_heartbeat", 32'(heartbeat), 32'd1);

    // Loss in RUN then a one-cycle glitch during QUALIFY restarts qualification
    @(negedge clk);
    locked = 1'b0;
    repeat (4) @(negedge clk);
    check("lost_cnt_two", 32'(lost_cnt), 32'd2);
    locked = 1'b1;
    repeat (6) @(negedge clk);
    check("qual_sys_rst", 32'(sys_rst), 32'd1);
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    wait_run(lat);
    check("glitch_requalify", 32'(lat), 32'd14);
    check("glitch_lost_cnt", 32'(lost_cnt), 32'd2);

    // Asynchronous reset between edges in RUN
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_sys_rst", 32'(sys_rst), 32'd1);
    check("async_heartbeat", 32'(heartbeat), 32'd0);
    check("async_lock_ok", 32'(lock_ok), 32'd0);
    check("async_lost_cnt", 32'(lost_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_run(lat);
    check("post_rst_latency", 32'(lat), 32'd14);

    // Saturation of the loss counter
    for (int i = 1; i <= 300; i++) begin
      lose_and_relock(rlat, lat);
      if (i == 1)   check("sat_first", 32'(lost_cnt), 32'd1);
      if (i == 254) check("sat_254", 32'(lost_cnt), 32'd254);
      if (i == 255) check("sat_255", 32'(lost_cnt), 32'd255);
      if (lat < 0) check("sat_relock_timeout", 32'(lat), 32'd14);
    end
    check("sat_300", 32'(lost_cnt), 32'd255);
    check("sat_last_relock", 32'(lat), 32'd14);
    check("sat_last_rst_latency", 32'(rlat), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/heartbeat_lock_mon.md
HEARTBEAT_LOCK_MON -- requirements
Module: heartbeat_lock_mon

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clk cycles per tick (1 ms at 100 MHz).
REQ-002 SHALL have parameter LOCK_STABLE_TICKS, default 16, ticks locked must hold before release.
REQ-003 SHALL have parameter BEAT_PERIOD_TICKS, default 1000, heartbeat period in ticks.
REQ-004 SHALL have parameter PULSE_TICKS, default 100, width of each heartbeat pulse in ticks.
REQ-005 SHALL have parameter GAP_TICKS, default 150, gap between the two pulses in ticks; 2*PULSE_TICKS+GAP_TICKS < BEAT_PERIOD_TICKS.
REQ-006 SHALL have port clk  input  1  100 MHz PLL output clock, rising-edge.
REQ-007 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-008 SHALL have port locked  input  1  PLL lock indication, treated as asynchronous to clk.
REQ-009 SHALL have port sys_rst  output  1  active-high downstream reset, high unless state is RUN.
REQ-010 SHALL have port lock_ok  output  1  high only in state RUN.
REQ-011 SHALL have port heartbeat  output  1  LED drive, double-pulse ("lub-dub") pattern in RUN.
REQ-012 SHALL have port tick  output  1  one-cycle pulse every TICK_DIV cycles.
REQ-013 SHALL have port lost_cnt  output  8  count of RUN-to-LOST transitions, saturating.

Function
REQ-014 SHALL pass locked through a two-flop synchronizer; only the second flop (locked_s) is used by logic.
REQ-015 SHALL run a prescaler 0..TICK_DIV-1 wrapping to 0; tick high in cycles where prescaler == TICK_DIV-1; prescaler cleared to 0 on entry to QUALIFY.
REQ-016 SHALL implement states WAIT_LOCK, QUALIFY, RUN, LOST.
REQ-017 WAIT_LOCK: locked_s=1 -> QUALIFY next edge, qual_cnt cleared; else stay.
REQ-018 QUALIFY: locked_s=0 -> WAIT_LOCK (takes priority over tick); on tick qual_cnt increments; on tick with qual_cnt == LOCK_STABLE_TICKS-1 -> RUN; RUN entered exactly LOCK_STABLE_TICKS*TICK_DIV cycles after QUALIFY entry.
REQ-019 RUN: beat_cnt cleared on entry, increments on tick, wraps BEAT_PERIOD_TICKS-1 -> 0; locked_s=0 -> LOST.
REQ-020 LOST: lasts exactly one cycle, then WAIT_LOCK unconditionally.
REQ-021 lost_cnt SHALL increment by 1 on each RUN->LOST edge, hold at 255; loss in QUALIFY SHALL NOT count.
REQ-022 sys_rst = NOT(state==RUN), lock_ok = (state==RUN), both registered, changing on the edge the state enters/leaves RUN.
REQ-023 heartbeat SHALL be high iff state==RUN and beat_cnt in [0, PULSE_TICKS) or [PULSE_TICKS+GAP_TICKS, 2*PULSE_TICKS+GAP_TICKS); low in all other states.
REQ-024 Latency: locked falling to sys_rst rising SHALL be 3 edges (2 sync + LOST entry).
REQ-025 Glitch of locked shorter than one cycle MAY be missed; any locked_s low during QUALIFY SHALL restart qualification from zero.

Reset
REQ-026 rst high SHALL asynchronously force state=WAIT_LOCK, sync flops=0, prescaler/qual_cnt/beat_cnt=0, lost_cnt=0, sys_rst=1, lock_ok=0, heartbeat=0, tick=0.
REQ-027 rst asserted mid-RUN SHALL assert sys_rst immediately (asynchronously) and clear lost_cnt; release of rst SHALL restart from WAIT_LOCK.

Verification (TICK_DIV=4, LOCK_STABLE_TICKS=3, BEAT_PERIOD_TICKS=20, PULSE_TICKS=2, GAP_TICKS=3)
REQ-028 Release rst, locked=1 before edge E0 -> QUALIFY at E2, RUN/sys_rst=0/lock_ok=1 at E14 (the 15th edge counting E0 as the first), heartbeat high at E14.
REQ-029 In RUN -> heartbeat high 8 cycles, low 12, high 8, low 52; period 80 cycles; tick every 4 cycles.
REQ-030 Drop locked for 1 cycle during QUALIFY -> return to WAIT_LOCK, lost_cnt stays 0, RUN entered 12 cycles after re-entering QUALIFY.
REQ-031 Drop locked in RUN -> sys_rst=1 and heartbeat=0 on 3rd edge, lost_cnt 0->1, re-lock repeats REQ-028 timing.
REQ-032 Force 300 lock losses from RUN -> lost_cnt saturates at 255.
REQ-033 Assert rst mid-RUN between edges -> sys_rst=1, heartbeat=0 before next edge; lost_cnt=0.
